// File: rtl/bk_sub_pipe.sv
// Two-stage pipelined Brent-Kung subtractor (a - b as a + ~b + 1) with valid/ready handshake.
// Optional build macro BKSUB_SATURATE_EN: unsigned saturating subtract (diff clamps to 0 on borrow).
module bk_sub_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned LOG = $clog2(WIDTH);

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_g, s1_p, s1_pr;
  logic             s1_am, s1_bm;

  logic [WIDTH-1:0] pb, gb, ug, upp;
  logic [WIDTH-1:0] dg, cvec, rawd, nd;
  logic             nov, nz, cout;
  logic             s2_load, accept;

  assign in_ready  = !rst && (!s1_valid || !s2_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;

  // Up-sweep: after level l, node i with (i+1) % 2^(l+1) == 0 spans 2^(l+1) bits.
  always_comb begin
    pb    = a ^ ~b;
    gb    = a & ~b;
    gb[0] = gb[0] | pb[0];
    ug    = gb;
    upp   = pb;
    for (int unsigned l = 0; l < LOG; l++) begin
      for (int unsigned i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
        ug[i]  = ug[i] | (upp[i] & ug[i - (1 << l)]);
        upp[i] = upp[i] & upp[i - (1 << l)];
      end
    end
  end

  // Down-sweep fills the remaining nodes from the highest level down, so every
  // lower operand is already a full prefix when it is used.
  always_comb begin
    dg = s1_g;
    for (int unsigned k = 0; k + 1 < LOG; k++) begin
      for (int unsigned i = (3 << (LOG - 2 - k)) - 1; i < WIDTH; i += (2 << (LOG - 2 - k))) begin
        dg[i] = dg[i] | (s1_p[i] & dg[i - (1 << (LOG - 2 - k))]);
      end
    end
    cvec = {dg[WIDTH-2:0], 1'b1};
    rawd = s1_pr ^ cvec;
    cout = dg[WIDTH-1];
`ifdef BKSUB_SATURATE_EN
    nd   = cout ? rawd : '0;
`else
    nd   = rawd;
`endif
    nov  = (s1_am != s1_bm) && (rawd[WIDTH-1] != s1_am);
    nz   = (nd == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_pr    <= '0;
      s1_am    <= 1'b0;
      s1_bm    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_g     <= ug;
      s1_p     <= upp;
      s1_pr    <= pb;
      s1_am    <= a[WIDTH-1];
      s1_bm    <= b[WIDTH-1];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      diff     <= nd;
      borrow   <= ~cout;
      overflow <= nov;
      zero     <= nz;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Self-checking bench for bk_sub_pipe: directed vectors, backpressure, random streaming, reset mid-flight.
module tb_bk_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        borrow, overflow, zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] d;
    logic        br;
    logic        ov;
    logic        z;
  } exp_t;

  bk_sub_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t m;
    int   sd;
    logic [15:0] wrapped;
    wrapped = x - y;
    sd      = int'($signed(x)) - int'($signed(y));
    m.br    = (x < y);
    m.ov    = (sd > 32767) || (sd < -32768);
`ifdef BKSUB_SATURATE_EN
    m.d     = m.br ? 16'h0000 : wrapped;
`else
    m.d     = wrapped;
`endif
    m.z     = (m.d == 16'h0000);
    return m;
  endfunction

  // Drives one cycle's inputs after the falling edge and reports which transfers the next rising edge performs.
  task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y, input logic r,
                       output logic fin, output logic fout);
    @(negedge clk);
    in_valid  = v;
    a         = x;
    b         = y;
    out_ready = r;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, borrow, overflow, zero} !== 5'b0 || diff !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got v=%b rdy=%b d=%h br=%b ov=%b z=%b, want all 0",
               out_valid, in_ready, diff, borrow, overflow, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'h1234, 16'h0000, 16'h8000, 16'hBEEF};
    logic [15:0] vb [4] = '{16'h0234, 16'h0001, 16'h0001, 16'hBEEF};
`ifdef BKSUB_SATURATE_EN
    logic [15:0] ed [4] = '{16'h1000, 16'h0000, 16'h7FFF, 16'h0000};
    logic        ez [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic [15:0] ed [4] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic        ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    logic        eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic fi, fo;
    int   lat;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, va[k], vb[k], 1'b1, fi, fo);
      total++;
      if (fi !== 1'b1) begin
        bad++;
        $display("FAIL directed_accept[%0d]: got %b want 1", k, fi);
      end
      lat = 0;
      fo  = 1'b0;
      while (!fo && lat < 6) begin
        cycle(1'b0, 16'h0, 16'h0, 1'b1, fi, fo);
        lat++;
      end
      total++;
      if (!fo || lat > 2) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d edges (seen=%b) want <=2", k, lat, fo);
      end else begin
        total++;
        if (diff !== ed[k] || borrow !== eb[k] || overflow !== eo[k] || zero !== ez[k]) begin
          bad++;
          $display("FAIL directed[%0d]: got d=%h br=%b ov=%b z=%b want d=%h br=%b ov=%b z=%b",
                   k, diff, borrow, overflow, zero, ed[k], eb[k], eo[k], ez[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic fi, fo;
    logic [15:0] expd [3] = '{16'd2, 16'd5, 16'd0};
    cycle(1'b1, 16'd5, 16'd3, 1'b0, fi, fo);
    total++;
    if (fi !== 1'b1) begin bad++; $display("FAIL bp_accept1: got %b want 1", fi); end
    cycle(1'b1, 16'd9, 16'd4, 1'b0, fi, fo);
    total++;
    if (fi !== 1'b1) begin bad++; $display("FAIL bp_accept2: got %b want 1", fi); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 16'd7, 16'd7, 1'b0, fi, fo);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || diff !== 16'd2) begin
        bad++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%0d want rdy=0 v=1 d=2", k, in_ready, out_valid, diff);
      end
    end
    cycle(1'b1, 16'd7, 16'd7, 1'b1, fi, fo);
    total++;
    if (fi !== 1'b1 || fo !== 1'b1 || diff !== expd[0]) begin
      bad++;
      $display("FAIL bp_release: got in=%b out=%b d=%0d want in=1 out=1 d=2", fi, fo, diff);
    end
    for (int k = 1; k < 3; k++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, fi, fo);
      total++;
      if (fo !== 1'b1 || diff !== expd[k] || zero !== (k == 2)) begin
        bad++;
        $display("FAIL bp_order[%0d]: got out=%b d=%0d z=%b want out=1 d=%0d", k, fo, diff, zero, expd[k]);
      end
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, fi, fo);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_stream();
    exp_t        q[$];
    exp_t        e;
    int          nin = 0;
    int          nout = 0;
    logic        held_v = 1'b0;
    logic [15:0] held_d = '0;
    logic        v, r, fi, fo;
    logic [15:0] x, y;
    for (int c = 0; c < 3000 && !(nin == 100 && nout == 100); c++) begin
      v = (nin < 100) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? x : 16'($urandom);
      cycle(v, x, y, r, fi, fo);
      if (held_v) begin
        total++;
        if (out_valid !== 1'b1 || diff !== held_d) begin
          bad++;
          $display("FAIL stream_hold: got v=%b d=%h want v=1 d=%h", out_valid, diff, held_d);
        end
      end
      if (fo) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: got unexpected result d=%h want none", diff);
        end else begin
          e = q.pop_front();
          if (diff !== e.d || borrow !== e.br || overflow !== e.ov || zero !== e.z) begin
            bad++;
            $display("FAIL stream[%0d]: got d=%h br=%b ov=%b z=%b want d=%h br=%b ov=%b z=%b",
                     nout, diff, borrow, overflow, zero, e.d, e.br, e.ov, e.z);
          end
        end
        nout++;
      end
      if (fi) begin
        q.push_back(model(x, y));
        nin++;
      end
      held_v = out_valid && !out_ready;
      held_d = diff;
    end
    total++;
    if (nin != 100 || nout != 100) begin
      bad++;
      $display("FAIL stream_count: got in=%0d out=%0d want 100/100", nin, nout);
    end
  endtask

  task automatic test_reset_midflight();
    logic fi, fo;
    cycle(1'b1, 16'h0000, 16'h0001, 1'b0, fi, fo);
    cycle(1'b1, 16'h0003, 16'h0001, 1'b0, fi, fo);
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || diff !== model(16'h0000, 16'h0001).d) begin
      bad++;
      $display("FAIL midflight_setup: got v=%b d=%h want v=1", out_valid, diff);
    end
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, borrow, overflow, zero} !== 5'b0 || diff !== 16'h0) begin
      bad++;
      $display("FAIL midflight_async: got v=%b rdy=%b d=%h br=%b ov=%b z=%b want all 0",
               out_valid, in_ready, diff, borrow, overflow, zero);
    end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midflight_ready_in_rst: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midflight_ready_after: got %b want 1", in_ready); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, fi, fo);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midflight_stale[%0d]: got v=%b d=%h want v=0", k, out_valid, diff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
